// File: rtl/ddr3_buf_regs.sv
// ddr3_buf_regs: CSR block for DDR3 frame-buffer channels.
// Holds per-channel buffer offsets and full/overrun flags, plus a
// one-shot test-write port with a two-state handshake FSM.
// Optional interrupt logic is built when DDR3_BUF_REGS_IRQ_EN is defined.
module ddr3_buf_regs #(
  parameter int NUM_BUF = 2,
  parameter int OFS_W   = 26
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     csr_read,
  input  logic                     csr_write,
  input  logic [7:0]               csr_addr,
  input  logic [31:0]              csr_wr_data,
  output logic [31:0]              csr_rd_data,
  output logic                     csr_rd_valid,
  output logic [NUM_BUF*OFS_W-1:0] buf_offset,
  output logic [NUM_BUF-1:0]       buf_empty,
  input  logic [NUM_BUF-1:0]       clear_buf,
  output logic [31:0]              test_addr,
  output logic [31:0]              test_wr_data,
  output logic                     test_wr,
  input  logic                     wr_finish,
  output logic                     irq
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [OFS_W-1:0]   offset_q [NUM_BUF];
  logic [OFS_W-1:0]   offset_d [NUM_BUF];
  logic [NUM_BUF-1:0] full_q, full_d;
  logic [NUM_BUF-1:0] overrun_q, overrun_d;
  logic [NUM_BUF-1:0] set_full, drain;
  logic [31:0]        test_addr_q, test_addr_d;
  logic [31:0]        test_data_q, test_data_d;
  logic               test_wr_q, test_wr_d;
  logic [0:0]         state_q, state_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [31:0]        rd_value;
  logic               start, finish;

`ifdef DDR3_BUF_REGS_IRQ_EN
  localparam int PW = NUM_BUF + 1;
  logic [PW-1:0] mask_q, mask_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          irq_q, irq_d;
`endif

  // Test-write handshake: a finish seen while the pulse is still high is too early to count
  always_comb begin
    start       = csr_write && (csr_addr == 8'h22) && csr_wr_data[0];
    finish      = (state_q == ST_PEND) && wr_finish && !test_wr_q;
    state_d     = state_q;
    test_wr_d   = 1'b0;
    test_addr_d = test_addr_q;
    test_data_d = test_data_q;
    if (state_q == ST_IDLE) begin
      if (csr_write && (csr_addr == 8'h20)) test_addr_d = csr_wr_data;
      if (csr_write && (csr_addr == 8'h21)) test_data_d = csr_wr_data;
      if (start) begin
        state_d   = ST_PEND;
        test_wr_d = 1'b1;
      end
    end else if (finish) begin
      state_d = ST_IDLE;
    end
  end

  // Per-channel offsets and full/overrun flags; a CSR set always beats a drain
  always_comb begin
    for (int i = 0; i < NUM_BUF; i++) begin
      offset_d[i] = offset_q[i];
      if (csr_write && (csr_addr == 8'(i))) offset_d[i] = csr_wr_data[OFS_W-1:0];
      set_full[i]  = csr_write && (csr_addr == 8'h10 + 8'(i)) && csr_wr_data[0];
      drain[i]     = clear_buf[i] && full_q[i] && !set_full[i];
      full_d[i]    = set_full[i] | (full_q[i] & ~drain[i]);
      overrun_d[i] = overrun_q[i];
      if (csr_write && (csr_addr == 8'h10 + 8'(i)) && csr_wr_data[1]) overrun_d[i] = 1'b0;
      if (set_full[i] && full_q[i] && !clear_buf[i]) overrun_d[i] = 1'b1;
    end
  end

`ifdef DDR3_BUF_REGS_IRQ_EN
  // Interrupt pending/mask; new events win over a same-cycle write-1-to-clear
  always_comb begin
    mask_d = mask_q;
    pend_d = pend_q;
    if (csr_write && (csr_addr == 8'h24)) mask_d = csr_wr_data[PW-1:0];
    if (csr_write && (csr_addr == 8'h25)) pend_d = pend_q & ~csr_wr_data[PW-1:0];
    pend_d = pend_d | {finish, drain};
    irq_d  = |(pend_d & mask_d);
  end
`endif

  // Read mux; unmapped addresses and absent channels fall through to zero
  always_comb begin
    rd_value = 32'h0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (csr_addr == 8'(i)) rd_value[OFS_W-1:0] = offset_q[i];
      if (csr_addr == 8'h10 + 8'(i)) rd_value[1:0] = {overrun_q[i], full_q[i]};
    end
    case (csr_addr)
      8'h20:   rd_value = test_addr_q;
      8'h21:   rd_value = test_data_q;
      8'h22:   rd_value[0] = (state_q == ST_PEND);
      8'h23:   rd_value[NUM_BUF-1:0] = full_q;
`ifdef DDR3_BUF_REGS_IRQ_EN
      8'h24:   rd_value[PW-1:0] = mask_q;
      8'h25:   rd_value[PW-1:0] = pend_q;
`endif
      default: ;
    endcase
    rd_valid_d = csr_read;
    rd_data_d  = csr_read ? rd_value : 32'h0;
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BUF; i++) offset_q[i] <= '0;
      full_q      <= '0;
      overrun_q   <= '0;
      test_addr_q <= 32'h0;
      test_data_q <= 32'h0;
      test_wr_q   <= 1'b0;
      state_q     <= ST_IDLE;
      rd_data_q   <= 32'h0;
      rd_valid_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BUF; i++) offset_q[i] <= offset_d[i];
      full_q      <= full_d;
      overrun_q   <= overrun_d;
      test_addr_q <= test_addr_d;
      test_data_q <= test_data_d;
      test_wr_q   <= test_wr_d;
      state_q     <= state_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

`ifdef DDR3_BUF_REGS_IRQ_EN
  // Interrupt registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  genvar g;
  for (g = 0; g < NUM_BUF; g++) begin : g_ofs
    assign buf_offset[g*OFS_W +: OFS_W] = offset_q[g];
  end

  assign buf_empty    = ~full_q;
  assign test_addr    = test_addr_q;
  assign test_wr_data = test_data_q;
  assign test_wr      = test_wr_q;
  assign csr_rd_data  = rd_data_q;
  assign csr_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ddr3_buf_regs.sv
// Testbench for ddr3_buf_regs (default parameters). Honours DDR3_BUF_REGS_IRQ_EN.
module tb_ddr3_buf_regs;

  localparam int NB = 2;
  localparam int OW = 26;
`ifdef DDR3_BUF_REGS_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [31:0] OFS_MASK = (32'h1 << OW) - 32'h1;
  localparam logic [31:0] P_MASK   = (32'h1 << (NB + 1)) - 32'h1;

  logic              clk, reset_n, csr_read, csr_write, wr_finish;
  logic [7:0]        csr_addr;
  logic [31:0]       csr_wr_data, csr_rd_data, test_addr, test_wr_data;
  logic              csr_rd_valid, test_wr, irq;
  logic [NB*OW-1:0]  buf_offset;
  logic [NB-1:0]     buf_empty, clear_buf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_ofs [NB];
  bit          m_full [NB];
  bit          m_ov [NB];
  logic [31:0] m_taddr, m_tdata, m_mask, m_irqp;
  bit          m_pend, m_twr, m_irq;
  bit          exp_rd_valid;
  logic [31:0] exp_rd_data;

  ddr3_buf_regs #(.NUM_BUF(NB), .OFS_W(OW)) dut (
    .clk(clk), .reset_n(reset_n), .csr_read(csr_read), .csr_write(csr_write),
    .csr_addr(csr_addr), .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data),
    .csr_rd_valid(csr_rd_valid), .buf_offset(buf_offset), .buf_empty(buf_empty),
    .clear_buf(clear_buf), .test_addr(test_addr), .test_wr_data(test_wr_data),
    .test_wr(test_wr), .wr_finish(wr_finish), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_ofs[i] = 0; m_full[i] = 0; m_ov[i] = 0;
    end
    m_taddr = 0; m_tdata = 0; m_mask = 0; m_irqp = 0;
    m_pend = 0; m_twr = 0; m_irq = 0;
    exp_rd_valid = 0; exp_rd_data = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int idx;
    idx = int'(a);
    if (idx < NB) return m_ofs[idx];
    if (idx >= 16 && idx < 16 + NB) return {30'b0, m_ov[idx-16], m_full[idx-16]};
    case (a)
      8'h20: return m_taddr;
      8'h21: return m_tdata;
      8'h22: return {31'b0, m_pend};
      8'h23: begin
        logic [31:0] v;
        v = 0;
        for (int i = 0; i < NB; i++) v[i] = m_full[i];
        return v;
      end
      8'h24: return IRQ_EN ? m_mask : 32'h0;
      8'h25: return IRQ_EN ? m_irqp : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // One clock of architectural behaviour: read sees the pre-edge state
  task automatic model_step(input bit rd, input bit wr, input logic [7:0] a,
                            input logic [31:0] d, input logic [NB-1:0] clr, input bit fin);
    logic [31:0] events;
    bit pulse_was_high;
    exp_rd_valid   = rd;
    exp_rd_data    = rd ? model_read(a) : 32'h0;
    events         = 0;
    pulse_was_high = m_twr;
    m_twr          = 0;
    for (int i = 0; i < NB; i++) begin
      bit ctrl;
      ctrl = wr && (int'(a) == 16 + i);
      if (ctrl && d[1]) m_ov[i] = 0;
      if (ctrl && d[0]) begin
        if (m_full[i] && !clr[i]) m_ov[i] = 1;
        m_full[i] = 1;
      end else if (clr[i] && m_full[i]) begin
        m_full[i] = 0;
        events[i] = 1;
      end
      if (wr && int'(a) == i) m_ofs[i] = d & OFS_MASK;
    end
    if (!m_pend) begin
      if (wr && a == 8'h20) m_taddr = d;
      if (wr && a == 8'h21) m_tdata = d;
      if (wr && a == 8'h22 && d[0]) begin
        m_pend = 1; m_twr = 1;
      end
    end else if (fin && !pulse_was_high) begin
      m_pend = 0;
      events[NB] = 1;
    end
    if (IRQ_EN) begin
      if (wr && a == 8'h24) m_mask = d & P_MASK;
      if (wr && a == 8'h25) m_irqp = m_irqp & ~d;
      m_irqp = (m_irqp | events) & P_MASK;
      m_irq  = |(m_irqp & m_mask);
    end
  endtask

  task automatic checkOutput();
    logic [NB*OW-1:0] exp_ofs;
    logic [NB-1:0]    exp_empty;
    for (int i = 0; i < NB; i++) begin
      exp_ofs[i*OW +: OW] = m_ofs[i][OW-1:0];
      exp_empty[i]        = !m_full[i];
    end
    compare("rd_valid", 64'(csr_rd_valid), 64'(exp_rd_valid));
    compare("rd_data", 64'(csr_rd_data), 64'(exp_rd_data));
    compare("buf_offset", 64'(buf_offset), 64'(exp_ofs));
    compare("buf_empty", 64'(buf_empty), 64'(exp_empty));
    compare("test_wr", 64'(test_wr), 64'(m_twr));
    compare("test_addr", 64'(test_addr), 64'(m_taddr));
    compare("test_wr_data", 64'(test_wr_data), 64'(m_tdata));
    compare("irq", 64'(irq), 64'(m_irq));
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [7:0] a,
                               input logic [31:0] d, input logic [NB-1:0] clr, input bit fin);
    csr_read = rd; csr_write = wr; csr_addr = a; csr_wr_data = d;
    clear_buf = clr; wr_finish = fin;
    model_step(rd, wr, a, d, clr, fin);
    @(posedge clk);
    #1;
    checkOutput();
    csr_read = 0; csr_write = 0; csr_addr = 0; csr_wr_data = 0;
    clear_buf = 0; wr_finish = 0;
  endtask

  task automatic check_all_zero(input string tag);
    compare({tag, " rd_valid"}, 64'(csr_rd_valid), 64'h0);
    compare({tag, " rd_data"}, 64'(csr_rd_data), 64'h0);
    compare({tag, " buf_offset"}, 64'(buf_offset), 64'h0);
    compare({tag, " buf_empty"}, 64'(buf_empty), 64'(2'b11));
    compare({tag, " test_wr"}, 64'(test_wr), 64'h0);
    compare({tag, " test_addr"}, 64'(test_addr), 64'h0);
    compare({tag, " test_wr_data"}, 64'(test_wr_data), 64'h0);
    compare({tag, " irq"}, 64'(irq), 64'h0);
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [NB-1:0] clr;
    logic [31:0] exp_rd;
    logic [NB-1:0] exp_empty;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] addr_pool [16] = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h10, 8'h11, 8'h12, 8'h20,
                                 8'h21, 8'h22, 8'h22, 8'h23, 8'h24, 8'h25, 8'h30, 8'hFF};
  int pulses;

  initial begin
    csr_read = 0; csr_write = 0; csr_addr = 0; csr_wr_data = 0;
    clear_buf = 0; wr_finish = 0;
    reset_n = 1'b1;
    model_reset();
    #3 reset_n = 1'b0;
    #4 check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Directed table: rd, wr, addr, data, clear_buf, expected read, expected buf_empty
    vecs.push_back('{0, 1, 8'h01, 32'h03FFFFFF, 2'b00, 32'h0,        2'b11});
    vecs.push_back('{1, 0, 8'h01, 32'h0,        2'b00, 32'h03FFFFFF, 2'b11});
    vecs.push_back('{0, 1, 8'h10, 32'h1,        2'b00, 32'h0,        2'b10});
    vecs.push_back('{0, 1, 8'h10, 32'h1,        2'b00, 32'h0,        2'b10});
    vecs.push_back('{1, 0, 8'h10, 32'h0,        2'b00, 32'h3,        2'b10});
    vecs.push_back('{0, 0, 8'h00, 32'h0,        2'b01, 32'h0,        2'b11});
    vecs.push_back('{0, 1, 8'h11, 32'h1,        2'b10, 32'h0,        2'b01});
    vecs.push_back('{1, 0, 8'h11, 32'h0,        2'b00, 32'h1,        2'b01});
    vecs.push_back('{1, 0, 8'h23, 32'h0,        2'b00, 32'h2,        2'b01});
    vecs.push_back('{0, 1, 8'h05, 32'hFFFFFFFF, 2'b00, 32'h0,        2'b01});
    vecs.push_back('{1, 0, 8'h05, 32'h0,        2'b00, 32'h0,        2'b01});
    vecs.push_back('{0, 1, 8'h00, 32'hFFFFFFFF, 2'b00, 32'h0,        2'b01});
    vecs.push_back('{1, 0, 8'h00, 32'h0,        2'b00, 32'h03FFFFFF, 2'b01});
    vecs.push_back('{1, 0, 8'h30, 32'h0,        2'b00, 32'h0,        2'b01});
    vecs.push_back('{0, 0, 8'h00, 32'h0,        2'b11, 32'h0,        2'b11});
    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].data, vecs[k].clr, 1'b0);
      compare($sformatf("vec%0d empty", k), 64'(buf_empty), 64'(vecs[k].exp_empty));
      if (vecs[k].rd) compare($sformatf("vec%0d rd", k), 64'(csr_rd_data), 64'(vecs[k].exp_rd));
    end
    compare("buf_offset ch1", 64'(buf_offset[51:26]), 64'h3FFFFFF);

    // Test-write handshake: one pulse, early finish and restart ignored
    applyStimulus(0, 1, 8'h20, 32'h12345678, 0, 0);
    applyStimulus(0, 1, 8'h21, 32'hCAFEF00D, 0, 0);
    pulses = 0;
    applyStimulus(0, 1, 8'h22, 32'h1, 0, 0); pulses += int'(test_wr);
    applyStimulus(0, 1, 8'h22, 32'h1, 0, 1); pulses += int'(test_wr);
    applyStimulus(0, 1, 8'h20, 32'h0, 0, 0); pulses += int'(test_wr);
    applyStimulus(1, 0, 8'h22, 32'h0, 0, 0); pulses += int'(test_wr);
    compare("pend read", 64'(csr_rd_data), 64'h1);
    applyStimulus(0, 0, 8'h00, 32'h0, 0, 1); pulses += int'(test_wr);
    applyStimulus(1, 0, 8'h22, 32'h0, 0, 0); pulses += int'(test_wr);
    compare("idle read", 64'(csr_rd_data), 64'h0);
    applyStimulus(1, 0, 8'h20, 32'h0, 0, 0);
    compare("held test_addr", 64'(csr_rd_data), 64'h12345678);
    compare("pulse count", 64'(pulses), 64'h1);

    // Interrupt path, or its absence in the default build
    applyStimulus(0, 1, 8'h24, 32'h1, 0, 0);
    applyStimulus(0, 1, 8'h10, 32'h1, 0, 0);
    applyStimulus(0, 0, 8'h00, 32'h0, 2'b01, 0);
    compare("irq after drain", 64'(irq), IRQ_EN ? 64'h1 : 64'h0);
    applyStimulus(1, 1, 8'h25, 32'h1, 0, 0);
    compare("irq after w1c", 64'(irq), 64'h0);

    // Reset while a test write is pending
    applyStimulus(0, 1, 8'h01, 32'h00ABCDEF, 0, 0);
    applyStimulus(0, 1, 8'h22, 32'h1, 0, 0);
    applyStimulus(0, 0, 8'h00, 32'h0, 0, 0);
    #2 reset_n = 1'b0;
    #1 check_all_zero("mid-pend reset");
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    pulses = 0;
    repeat (4) begin
      applyStimulus(0, 0, 8'h00, 32'h0, 0, 0);
      pulses += int'(test_wr);
    end
    applyStimulus(1, 0, 8'h22, 32'h0, 0, 0);
    compare("post-reset pend", 64'(csr_rd_data), 64'h0);
    compare("post-reset pulses", 64'(pulses), 64'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                    addr_pool[$urandom_range(0, 15)], d,
                    ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0,
                    $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
